if_fetch_stage: RTL

- Instruction-fetch stage that directly feeds the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Buffers up to 2 fetched {PC, instr} pairs so fetch keeps running across IF/ID stalls.
- Handles EX-stage redirects (taken branch/jump) by flushing the buffer and refetching from the target.

---
 rtl/if_fetch_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// buffers up to two {pc, instr} pairs for IF/ID. Optional FETCH_PERF_CNT_EN adds counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] instr_out,
    output logic        instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] wait_cnt
`endif
);

    logic [31:0] pc;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        consume;
    logic        not_full;
    logic        transfer;

    // A request is issued whenever the buffer will have room at the edge,
    // counting the slot freed by a same-cycle consume.
    always_comb begin
        consume  = !stall && (count != 2'd0);
        not_full = (count != 2'd2);
        imem_req = rst_n && !redirect && (not_full || consume);
        transfer = imem_req && imem_ready;
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (redirect) begin
            pc     <= redirect_pc;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (transfer) begin
                pc     <= pc + 32'd4;
                wr_ptr <= ~wr_ptr;
            end
            if (consume) begin
                rd_ptr <= ~rd_ptr;
            end
            if (transfer && !consume) begin
                count <= count + 2'd1;
            end else if (!transfer && consume) begin
                count <= count - 2'd1;
            end
        end
    end

    // Buffer storage carries no reset; entries are only visible while count says so.
    always_ff @(posedge clk) begin
        if (transfer) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    always_comb begin
        instr_valid = (count != 2'd0);
        PC_out      = 32'h0;
        instr_out   = NOP_INSTR;
        if (instr_valid) begin
            PC_out    = fifo_pc[rd_ptr];
            instr_out = fifo_instr[rd_ptr];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
            wait_cnt  <= 32'd0;
        end else begin
            if (transfer) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (imem_req && !imem_ready) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
